// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-addressed data memory.
// Sub-word stores go through a read-modify-write sequence.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] rdata,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, STORE, RESP} state_t;

  state_t      state_q;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;
  logic [31:0] wbuf_q;
  logic [31:0] rdata_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;
  logic        memRead_q;
  logic        memWrite_q;

  logic        legal;
  logic [4:0]  byteShift;
  logic [4:0]  halfShift;
  logic [4:0]  laneShift;
  logic [31:0] laneMask;
  logic [31:0] shiftedRead;
  logic [7:0]  byteLane;
  logic [15:0] halfLane;
  logic [31:0] loadData_d;
  logic [31:0] mergedWord_d;

  // Alignment and funct3 legality of the incoming request.
  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~addr[0];
      3'b010:  legal = (addr[1:0] == 2'b00);
      3'b100:  legal = ~we;
      3'b101:  legal = ~we & ~addr[0];
      default: legal = 1'b0;
    endcase
  end

  assign byteShift   = {addr_q[1:0], 3'b000};
  assign halfShift   = {addr_q[1], 4'b0000};
  assign shiftedRead = mem_rdata >> byteShift;
  assign byteLane    = shiftedRead[7:0];
  assign halfLane    = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    loadData_d = mem_rdata;
    case (funct3_q)
      3'b000:  loadData_d = {{24{byteLane[7]}}, byteLane};
      3'b001:  loadData_d = {{16{halfLane[15]}}, halfLane};
      3'b100:  loadData_d = {24'h000000, byteLane};
      3'b101:  loadData_d = {16'h0000, halfLane};
      default: loadData_d = mem_rdata;
    endcase
  end

  // funct3_q[0] distinguishes SH from SB once the request is known to be legal.
  assign laneShift    = funct3_q[0] ? halfShift : byteShift;
  assign laneMask     = funct3_q[0] ? (32'h0000FFFF << halfShift) : (32'h000000FF << byteShift);
  assign mergedWord_d = (mem_rdata & ~laneMask) | ((wdata_q << laneShift) & laneMask);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      funct3_q   <= '0;
      wdata_q    <= '0;
      wbuf_q     <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q   <= addr;
            funct3_q <= funct3;
            wdata_q  <= wdata;
            busy_q   <= 1'b1;
            if (!legal) begin
              error_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= RESP;
            end else if (!we) begin
              memRead_q <= 1'b1;
              state_q   <= LOAD;
            end else if (funct3 == 3'b010) begin
              wbuf_q     <= wdata;
              memWrite_q <= 1'b1;
              state_q    <= STORE;
            end else begin
              memRead_q <= 1'b1;
              state_q   <= RMW_RD;
            end
          end
        end
        LOAD: begin
          rdata_q <= loadData_d;
          done_q  <= 1'b1;
          state_q <= RESP;
        end
        RMW_RD: begin
          wbuf_q     <= mergedWord_d;
          memWrite_q <= 1'b1;
          state_q    <= STORE;
        end
        STORE: begin
          done_q  <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          busy_q  <= 1'b0;
          error_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          error_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign rdata     = rdata_q;
  assign MemRead   = memRead_q;
  assign MemWrite  = memWrite_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wbuf_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64-word behavioural data memory.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] rdata;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [64];
  int vectorCount;
  int missCount;

  load_store_unit dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .error(error),
    .rdata(rdata), .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: combinational read, write on the rising edge.
  assign mem_rdata = MemRead ? mem[mem_addr[7:2]] : 32'h0;
  always @(posedge clk) begin
    if (MemWrite) mem[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one request and watches it until done (at most 8 cycles).
  task automatic applyStimulus(input logic weIn, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, output int doneCycle, output int writeCycles,
                               output int readCycles, output logic errSeen, output logic [31:0] addrSeen);
    doneCycle   = 0;
    writeCycles = 0;
    readCycles  = 0;
    errSeen     = 1'b0;
    addrSeen    = 32'hFFFFFFFF;
    @(negedge clk);
    checkOutput("busy_before_accept", {31'b0, busy}, 32'h0);
    req = 1'b1; we = weIn; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (MemWrite) writeCycles++;
      if (MemRead) begin
        readCycles++;
        addrSeen = mem_addr;
      end
      if (done) begin
        doneCycle = c;
        errSeen   = error;
        break;
      end
      @(posedge clk); #1;
    end
    if (doneCycle == 0) checkOutput("done_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
  endtask

  int dc, wc, rc;
  logic es;
  logic [31:0] as;
  int doneCount, firstDone, secondDone;
  logic busyGap, sawWrite;

  initial begin
    vectorCount = 0;
    missCount   = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    reset = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
    #12;
    checkOutput("rst_busy", {31'b0, busy}, 32'h0);
    checkOutput("rst_done", {31'b0, done}, 32'h0);
    checkOutput("rst_error", {31'b0, error}, 32'h0);
    checkOutput("rst_memread", {31'b0, MemRead}, 32'h0);
    checkOutput("rst_memwrite", {31'b0, MemWrite}, 32'h0);
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // SW then LW of a full word.
    applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, dc, wc, rc, es, as);
    checkOutput("sw_done_cycle", dc, 2);
    checkOutput("sw_write_cycles", wc, 1);
    checkOutput("sw_read_cycles", rc, 0);
    checkOutput("sw_mem", mem[4], 32'hDEADBEEF);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, dc, wc, rc, es, as);
    checkOutput("lw_done_cycle", dc, 2);
    checkOutput("lw_rdata", rdata, 32'hDEADBEEF);
    checkOutput("lw_mem_addr", as, 32'h10);

    // Byte store via read-modify-write, then signed/unsigned byte loads.
    applyStimulus(1'b1, 3'b000, 32'h11, 32'h000000AA, dc, wc, rc, es, as);
    checkOutput("sb_done_cycle", dc, 3);
    checkOutput("sb_write_cycles", wc, 1);
    checkOutput("sb_mem", mem[4], 32'hDEADAAEF);
    applyStimulus(1'b0, 3'b000, 32'h11, 32'h0, dc, wc, rc, es, as);
    checkOutput("lb_rdata", rdata, 32'hFFFFFFAA);
    checkOutput("lb_mem_addr", as, 32'h10);
    applyStimulus(1'b0, 3'b100, 32'h11, 32'h0, dc, wc, rc, es, as);
    checkOutput("lbu_rdata", rdata, 32'h000000AA);

    // Halfword store and loads on both halves.
    applyStimulus(1'b1, 3'b001, 32'h12, 32'h00001234, dc, wc, rc, es, as);
    checkOutput("sh_done_cycle", dc, 3);
    checkOutput("sh_mem", mem[4], 32'h1234AAEF);
    applyStimulus(1'b0, 3'b001, 32'h12, 32'h0, dc, wc, rc, es, as);
    checkOutput("lh_hi_rdata", rdata, 32'h00001234);
    applyStimulus(1'b0, 3'b001, 32'h10, 32'h0, dc, wc, rc, es, as);
    checkOutput("lh_lo_rdata", rdata, 32'hFFFFAAEF);
    applyStimulus(1'b0, 3'b101, 32'h10, 32'h0, dc, wc, rc, es, as);
    checkOutput("lhu_lo_rdata", rdata, 32'h0000AAEF);

    // Out-of-range address passes through unchanged and aliases word 4.
    applyStimulus(1'b0, 3'b010, 32'h00000110, 32'h0, dc, wc, rc, es, as);
    checkOutput("hiaddr_mem_addr", as, 32'h00000110);
    checkOutput("hiaddr_rdata", rdata, 32'h1234AAEF);

    // Misaligned and illegal requests.
    applyStimulus(1'b0, 3'b010, 32'h13, 32'h0, dc, wc, rc, es, as);
    checkOutput("lw_mis_done_cycle", dc, 1);
    checkOutput("lw_mis_error", {31'b0, es}, 32'h1);
    checkOutput("lw_mis_reads", rc, 0);
    checkOutput("lw_mis_rdata", rdata, 32'h1234AAEF);
    applyStimulus(1'b1, 3'b001, 32'h11, 32'h0000BEEF, dc, wc, rc, es, as);
    checkOutput("sh_mis_done_cycle", dc, 1);
    checkOutput("sh_mis_error", {31'b0, es}, 32'h1);
    checkOutput("sh_mis_access", rc + wc, 0);
    checkOutput("sh_mis_mem", mem[4], 32'h1234AAEF);
    applyStimulus(1'b0, 3'b011, 32'h10, 32'h0, dc, wc, rc, es, as);
    checkOutput("ld_f3_error", {31'b0, es}, 32'h1);
    applyStimulus(1'b1, 3'b100, 32'h10, 32'h0, dc, wc, rc, es, as);
    checkOutput("st_f3_error", {31'b0, es}, 32'h1);
    checkOutput("st_f3_mem", mem[4], 32'h1234AAEF);
    applyStimulus(1'b0, 3'b000, 32'h10, 32'h0, dc, wc, rc, es, as);
    checkOutput("lb_ok_error", {31'b0, es}, 32'h0);
    checkOutput("lb_ok_rdata", rdata, 32'hFFFFFFEF);

    // req held high across two LW requests.
    doneCount = 0; firstDone = 0; secondDone = 0; busyGap = 1'b1;
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h10;
    @(posedge clk); #1;
    for (int c = 1; c <= 6; c++) begin
      if (done) begin
        doneCount++;
        if (doneCount == 1) firstDone = c;
        else secondDone = c;
      end
      if (c == 3) busyGap = busy;
      if (c == 5) req = 1'b0;
      @(posedge clk); #1;
    end
    checkOutput("b2b_done_count", doneCount, 2);
    checkOutput("b2b_first_done", firstDone, 2);
    checkOutput("b2b_second_done", secondDone, 5);
    checkOutput("b2b_busy_gap", {31'b0, busyGap}, 32'h0);

    // Reset during the read phase of an SB aborts the store.
    applyStimulus(1'b1, 3'b010, 32'h14, 32'h11223344, dc, wc, rc, es, as);
    checkOutput("sw2_mem", mem[5], 32'h11223344);
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h14; wdata = 32'h00000055;
    @(posedge clk); #1;
    req = 1'b0;
    checkOutput("abort_in_rmw", {31'b0, MemRead}, 32'h1);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_memread", {31'b0, MemRead}, 32'h0);
    checkOutput("abort_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    sawWrite = 1'b0; doneCount = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (MemWrite) sawWrite = 1'b1;
      if (done) doneCount++;
    end
    checkOutput("abort_no_write", {31'b0, sawWrite}, 32'h0);
    checkOutput("abort_no_done", doneCount, 0);
    checkOutput("abort_mem", mem[5], 32'h11223344);
    applyStimulus(1'b0, 3'b010, 32'h14, 32'h0, dc, wc, rc, es, as);
    checkOutput("post_abort_done", dc, 2);
    checkOutput("post_abort_rdata", rdata, 32'h11223344);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-side initiator for the RV32I datapath: accepts one load or store request from the core and drives the word-addressed data memory port (MemRead, MemWrite, address, write data, combinational read data). The unit performs byte/halfword extraction with sign or zero extension for loads. The data memory only writes full words, so byte and halfword stores are done as read-modify-write. It sits between the execute/memory stage and the data memory and reports completion with a one-cycle done pulse.

## Interface

Parameters:
- none; the data path is fixed at 32 bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  request strobe; sampled only when busy=0.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I width code.
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - stores: 000 SB, 001 SH, 010 SW.
- addr  in  32  byte address.
- wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- busy  out  1  high while a request is in flight.
- done  out  1  one-cycle completion pulse.
- error  out  1  valid with done; misaligned or illegal funct3.
- rdata  out  32  extended load result; holds until the next successful load.
- MemRead  out  1  memory read enable.
- MemWrite  out  1  memory write enable; memory writes on the rising edge.
- mem_addr  out  32  word-aligned address: {addr_q[31:2], 2'b00}.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  combinational read data from memory, valid while MemRead=1.

## Operation

FSM states: IDLE, LOAD, RMW_RD, STORE, RESP.

- IDLE:
  - busy=0.
  - On req, latch addr, funct3, we and wdata.
  - Check legality:
    - Halfword access requires addr[0]=0.
    - Word access requires addr[1:0]=00.
    - Load funct3 in {011, 110, 111} is illegal.
    - Store funct3 ≥ 011 is illegal.
  - Next state:
    - Illegal or misaligned → RESP with error_q=1.
    - Load → LOAD.
    - SW → STORE, with wbuf=wdata.
    - SB or SH → RMW_RD.
- LOAD:
  - MemRead=1.
  - Register into rdata, selected by addr_q[1:0]:
    - byte lane = mem_rdata[8*a+7 : 8*a], where a = addr_q[1:0].
    - halfword lane = mem_rdata[16*h+15 : 16*h], where h = addr_q[1].
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - Next state: RESP.
- RMW_RD:
  - MemRead=1.
  - wbuf = mem_rdata with the addressed lane replaced by wdata_q[7:0] (SB) or wdata_q[15:0] (SH).
  - Next state: STORE.
- STORE:
  - MemWrite=1, mem_wdata=wbuf.
  - Next state: RESP.
- RESP:
  - done=1; error=error_q.
  - Next state: IDLE. The unit can accept a new req in the following cycle.
- Output rules:
  - busy = (state != IDLE).
  - MemRead and MemWrite are never high together, and both are 0 outside the states listed above.
  - A failed (error) request never asserts MemRead or MemWrite and leaves rdata unchanged.
  - req while busy=1 is ignored. There is no queueing; the core must hold or reissue.

## Timing

- Request accepted at edge N: IDLE with req=1.
- LW/LH/LB: LOAD in cycle N+1; done and rdata valid in cycle N+2.
- SW: STORE in N+1 (memory written at the end of N+1); done in N+2.
- SB/SH: RMW_RD in N+1, STORE in N+2, done in N+3.
- Error: done=1 and error=1 in N+1.
- Reset values:
  - state = IDLE.
  - busy, done, error, MemRead, MemWrite = 0.
  - rdata, mem_wdata, mem_addr, and all latched registers = 0.
- Reset mid-operation:
  - Aborts immediately; MemRead and MemWrite drop asynchronously.
  - If reset arrives before the STORE cycle, no write occurs.
  - No done pulse is issued for the aborted request.
- Address above the 64-word memory range: the full address is passed through unchanged; aliasing is the memory's behaviour.

## Test plan

1. After reset, SW 0xDEADBEEF @0x10, then LW @0x10 → MemWrite high exactly one cycle; rdata = 0xDEADBEEF with done at N+2.
2. SB wdata=0x000000AA @0x11 → memory word 0x10 = 0xDEADAAEF; done at N+3. Then LB @0x11 → 0xFFFFFFAA, and LBU @0x11 → 0x000000AA.
3. SH 0x1234 @0x12 → word = 0x1234AAEF. Then LH @0x12 → 0x00001234, and LH @0x10 → 0xFFFFAAEF.
4. LW @0x13, and separately SH @0x11 → done and error in N+1; MemRead and MemWrite stay 0; memory and rdata are unchanged.
5. Hold req=1 continuously for two back-to-back LW requests → the second is accepted only in the cycle after done; busy is never high during the accept cycle.
6. Assert reset during RMW_RD of an SB → MemWrite never rises, no done pulse, busy=0; the next LW completes normally.
